// File: rtl/cpu_mem_responder_if.sv
// cpu <-> memory responder bus: fetch port and load/store port.
// Field names follow the cpu-side port names.
interface cpu_mem_responder_if;
  logic [15:0] i_pc_addr;
  logic        i_pc_rd;
  logic [15:0] o_pc_rddata;
  logic [15:0] i_ldst_addr;
  logic        i_ldst_rd;
  logic        i_ldst_wr;
  logic [15:0] i_ldst_wrdata;
  logic [15:0] o_ldst_rddata;

  modport master (
    output i_pc_addr, i_pc_rd,
    output i_ldst_addr, i_ldst_rd,
    output i_ldst_wr, i_ldst_wrdata,
    input  o_pc_rddata, o_ldst_rddata
  );

  modport slave (
    input  i_pc_addr, i_pc_rd,
    input  i_ldst_addr, i_ldst_rd,
    input  i_ldst_wr, i_ldst_wrdata,
    output o_pc_rddata, o_ldst_rddata
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Dual-port word RAM plus LED/cycle-counter MMIO window for the cpu.
// Build option MEM_FWD_EN: write-first fetch on a same-word store.
module cpu_mem_responder #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [15:0] MMIO_BASE = 16'hF000,
  parameter string       INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               reset,
  cpu_mem_responder_if.slave bus,
  output logic [15:0]        o_leds
);
  localparam int          IW      = $clog2(MEM_WORDS);
  localparam logic [16:0] RAM_END = 17'(2 * MEM_WORDS);

  logic [15:0]   mem [MEM_WORDS];
  logic [IW-1:0] pc_idx;
  logic [IW-1:0] ls_idx;
  logic          pc_ram;
  logic          ls_ram;
  logic          ls_mmio;
  logic [2:0]    ls_off;
  logic          wr_ram;
  logic          wr_leds;
  logic [15:0]   pc_d;
  logic [15:0]   ls_d;
  logic [15:0]   pc_q;
  logic [15:0]   ls_q;
  logic [15:0]   leds;
  logic [15:0]   cycles;
  logic          unused_bits;

  assign pc_idx  = bus.i_pc_addr[IW:1];
  assign ls_idx  = bus.i_ldst_addr[IW:1];
  assign pc_ram  = {1'b0, bus.i_pc_addr} < RAM_END;
  assign ls_ram  = {1'b0, bus.i_ldst_addr} < RAM_END;
  assign ls_mmio = bus.i_ldst_addr[15:4] == MMIO_BASE[15:4];
  assign ls_off  = bus.i_ldst_addr[3:1];
  assign wr_ram  = bus.i_ldst_wr & ls_ram;
  assign wr_leds = bus.i_ldst_wr & ls_mmio & (ls_off == 3'd0);

  assign unused_bits = bus.i_pc_addr[0] ^ bus.i_ldst_addr[0];

  assign bus.o_pc_rddata   = pc_q;
  assign bus.o_ldst_rddata = ls_q;
  assign o_leds            = leds;

  // Fetch data: RAM only; MMIO and unmapped fetches read as zero
  always_comb begin
    pc_d = '0;
    if (pc_ram) pc_d = mem[pc_idx];
`ifdef MEM_FWD_EN
    if (pc_ram && wr_ram && (pc_idx == ls_idx))
      pc_d = bus.i_ldst_wrdata;
`endif
  end

  // Load data: pre-edge RAM word, LED reg or counter, else zero
  always_comb begin
    ls_d = '0;
    unique case (1'b1)
      ls_ram:                      ls_d = mem[ls_idx];
      ls_mmio && (ls_off == 3'd0): ls_d = leds;
      ls_mmio && (ls_off == 3'd1): ls_d = cycles;
      default:                     ls_d = '0;
    endcase
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ram) mem[ls_idx] <= bus.i_ldst_wrdata;
  end

  // Registered fetch data, held when no fetch strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          pc_q <= '0;
    else if (bus.i_pc_rd) pc_q <= pc_d;
  end

  // Registered load data, held when no load strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            ls_q <= '0;
    else if (bus.i_ldst_rd) ls_q <= ls_d;
  end

  // LED register, written through the MMIO window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       leds <= '0;
    else if (wr_leds) leds <= bus.i_ldst_wrdata;
  end

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycles <= '0;
    else        cycles <= cycles + 16'd1;
  end
endmodule
